// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and types for the fetch stage
//
// Purpose: common definitions imported by the fetch stage, its prefetch FIFO
// and the instruction-memory interface.
// Ports: none (package).
package if_fetch_pkg;

    localparam int INST_W      = 32;
    localparam int INST_ADDR_W = 32;

    localparam logic [INST_W-1:0]      INST_NOP        = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] CPU_RESET_ADDR  = 32'h0000_0000;

    localparam logic RST_ENABLE      = 1'b0;
    localparam logic HOLD_ENABLE     = 1'b1;
    localparam logic JUMP_ENABLE     = 1'b1;
    localparam logic IMEM_REQ_ENABLE = 1'b1;

    // One prefetched word together with the address it was fetched from.
    typedef struct packed {
        logic [INST_W-1:0]      inst;
        logic [INST_ADDR_W-1:0] addr;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - pipelined request/grant/response instruction-memory port
//
// Purpose: bundles the instruction-memory handshake.
// Ports: imem_req_o/imem_addr_o (fetch side -> memory),
//        imem_gnt_i/imem_rvalid_i/imem_rdata_i (memory -> fetch side).
// Modports: master = fetch stage, slave = memory.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   imem_req_o;
    logic [INST_ADDR_W-1:0] imem_addr_o;
    logic                   imem_gnt_i;
    logic                   imem_rvalid_i;
    logic [INST_W-1:0]      imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - in-order prefetch FIFO holding {instruction, address}
//
// Purpose: circular buffer of fetched words; head is visible combinationally
// from registered storage.
// Ports: clk, resetn (sync active-low), flush (empties FIFO), push/push_data,
//        pop, head/head_valid (oldest entry), count (entries held).
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   storage [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           full;
    logic           push_ok;
    logic           pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign pop_ok     = pop & head_valid & !flush;
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign push_ok    = push & !flush & (!full | pop_ok);
    assign head       = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RISC-V instruction-fetch stage with prefetch FIFO
//
// Purpose: owns the fetch PC, issues word fetches on the pipelined imem port,
// buffers returned words in order and presents the FIFO head to pc_id.
// Ports: clk_100MHz, arst_n (sync active-low reset), hold_ena_i (pipeline
//        hold), jump_ena_i/jump_addr_i (redirect from EX), imem (master side
//        of the memory port), inst_o/inst_addr_o/inst_valid_o (to pc_id).
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                     FIFO_DEPTH = 2,
    parameter logic [INST_ADDR_W-1:0] RESET_ADDR = CPU_RESET_ADDR
) (
    input  logic                   clk_100MHz,
    input  logic                   arst_n,
    input  logic                   hold_ena_i,
    input  logic                   jump_ena_i,
    input  logic [INST_ADDR_W-1:0] jump_addr_i,
    if_fetch_if.master             imem,
    output logic [INST_W-1:0]      inst_o,
    output logic [INST_ADDR_W-1:0] inst_addr_o,
    output logic                   inst_valid_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [INST_ADDR_W-1:0] fetch_pc;
    logic [INST_ADDR_W-1:0] resp_pc;
    logic [INST_ADDR_W-1:0] jump_target;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          discard;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            demand;
    logic                   active;
    logic                   hold;
    logic                   jump;
    logic                   pop;
    logic                   req;
    logic                   gnt;
    logic                   resp;
    logic                   push;
    logic                   head_valid;
    fetch_entry_t           head;
    fetch_entry_t           push_data;

    assign active      = (arst_n != RST_ENABLE);
    assign hold        = (hold_ena_i == HOLD_ENABLE);
    assign jump        = (jump_ena_i == JUMP_ENABLE);
    assign jump_target = word_align(jump_addr_i);

    assign inst_valid_o = active & head_valid;
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head.addr : CPU_RESET_ADDR;

    assign pop = inst_valid_o & !hold & !jump;

    // Words in flight plus words buffered, crediting the one leaving this
    // cycle, must stay below the FIFO depth so every response has a slot.
    assign demand = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
    assign req    = active & !jump & (demand < (CW+1)'(FIFO_DEPTH));

    assign imem.imem_req_o  = req ? IMEM_REQ_ENABLE : ~IMEM_REQ_ENABLE;
    assign imem.imem_addr_o = fetch_pc;

    assign gnt  = req & imem.imem_gnt_i;
    // Responses with nothing outstanding belong to a transfer cut off by reset.
    assign resp = imem.imem_rvalid_i & (outstanding != '0);
    // Words owed to a pre-redirect request, or arriving in the jump cycle, are dropped.
    assign push = resp & (discard == '0) & !jump;

    assign push_data.inst = imem.imem_rdata_i;
    assign push_data.addr = resp_pc;

    always_ff @(posedge clk_100MHz) begin
        if (!arst_n) begin
            fetch_pc    <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(gnt) - CW'(resp);
            if (jump) begin
                fetch_pc <= jump_target;
                resp_pc  <= jump_target;
                // Everything still in flight after this cycle is stale.
                discard  <= outstanding - CW'(resp);
            end else begin
                if (gnt) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_100MHz),
        .resetn     (arst_n),
        .flush      (jump),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for the if_fetch stage
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int                     FIFO_DEPTH = 2;
    localparam logic [INST_ADDR_W-1:0] RESET_ADDR = CPU_RESET_ADDR;

    typedef struct {
        logic        h;
        logic        j;
        logic [31:0] ja;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] iaddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk;
    logic        rstn;
    logic        hold;
    logic        jump;
    logic [31:0] jaddr;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    if_fetch_if bus ();

    if_fetch #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clk_100MHz   (clk),
        .arst_n       (rstn),
        .hold_ena_i   (hold),
        .jump_ena_i   (jump),
        .jump_addr_i  (jaddr),
        .imem         (bus),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat_lo   = 1;
    int          lat_hi   = 1;
    bit          check_inflight = 0;
    mreq_t       mq[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic        s_req;
    logic        s_gnt;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [31:0] s_iaddr;
    logic        rv_now;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // One clock cycle: drive inputs, let the memory model answer, check the
    // reference model, then advance the model at the edge.
    task automatic step(input logic h, input logic j, input logic [31:0] ja, input int gnt_pct);
        logic pop_s;
        hold  = h;
        jump  = j;
        jaddr = ja;
        rv_now = 1'b0;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc) rv_now = 1'b1;
        end
        bus.imem_rvalid_i = rv_now;
        if (rv_now) bus.imem_rdata_i = memf(mq[0].addr);
        else        bus.imem_rdata_i = $urandom;
        #1;
        s_gnt = ($urandom_range(99) < 32'(gnt_pct));
        bus.imem_gnt_i = s_gnt;
        #1;
        s_req   = bus.imem_req_o;
        s_addr  = bus.imem_addr_o;
        s_valid = inst_valid;
        s_inst  = inst;
        s_iaddr = inst_addr;
        if (!s_valid) begin
            chk("idle_inst", s_inst, INST_NOP);
            chk("idle_addr", s_iaddr, CPU_RESET_ADDR);
        end
        if (j || !rstn) chk("no_req_jump_or_reset", 32'(s_req), 32'd0);
        if (!rstn) chk("valid_in_reset", 32'(s_valid), 32'd0);
        if (s_req && s_gnt) chk("fetch_addr", s_addr, exp_fetch);
        pop_s = s_valid & !h & !j & rstn;
        if (pop_s) begin
            chk("pop_addr", s_iaddr, exp_pc);
            chk("pop_inst", s_inst, memf(exp_pc));
        end
        @(posedge clk);
        #1;
        if (rv_now) void'(mq.pop_front());
        if (s_req && s_gnt)
            mq.push_back('{s_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
        if (!rstn) begin
            exp_pc    = RESET_ADDR;
            exp_fetch = RESET_ADDR;
        end else if (j) begin
            exp_pc    = ja & ~32'd3;
            exp_fetch = ja & ~32'd3;
        end else begin
            if (s_req && s_gnt) exp_fetch = exp_fetch + 32'd4;
            if (pop_s) exp_pc = exp_pc + 32'd4;
        end
        if (check_inflight) chk("inflight_cap", 32'(mq.size() <= FIFO_DEPTH), 32'd1);
        cyc++;
    endtask

    task automatic reset_cycles(input int n);
        rstn = 1'b0;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 100);
        rstn = 1'b1;
    endtask

    vec_t        vecs[13];
    logic [31:0] frozen_inst;
    logic [31:0] frozen_addr;
    int          grants;
    bit          seen_req;
    bit          seen_valid;
    logic        rj;
    logic [31:0] rt;

    initial begin
        // Zero-wait start-up, redirect to the top of the address space, then hold.
        vecs[0]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0004, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0008, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_000C, 1'b1, 32'h4};
        vecs[4]  = '{1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, 32'h0000_0010, 1'b1, 32'h8};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0008, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_000C, 1'b1, 32'h4};
        vecs[12] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0010, 1'b1, 32'h8};

        rstn = 1'b0;
        hold = 1'b0;
        jump = 1'b0;
        jaddr = 32'd0;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = 32'd0;
        exp_pc = RESET_ADDR;
        exp_fetch = RESET_ADDR;
        @(posedge clk);
        #1;
        reset_cycles(2);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].h, vecs[i].j, vecs[i].ja, 100);
            chk($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].req));
            chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_iaddr", i), s_iaddr, vecs[i].iaddr);
            chk($sformatf("vec%0d_inst", i), s_inst, vecs[i].valid ? memf(vecs[i].iaddr) : INST_NOP);
        end

        // Five-cycle hold from steady state.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 100);
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'd0, 100);
            if (i == 0) begin
                frozen_inst = s_inst;
                frozen_addr = s_iaddr;
            end
            if (s_req && s_gnt) grants++;
            chk("hold_valid", 32'(s_valid), 32'd1);
            chk("hold_inst_frozen", s_inst, frozen_inst);
            chk("hold_addr_frozen", s_iaddr, frozen_addr);
        end
        chk("hold_grants_le_depth", 32'(grants <= FIFO_DEPTH), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 100);

        // Jump, hold and a response all in one cycle.
        step(1'b1, 1'b1, 32'h0000_0200, 100);
        chk("jhr_rvalid_present", 32'(rv_now), 32'd1);
        step(1'b0, 1'b0, 32'd0, 100);
        chk("jhr_valid", 32'(s_valid), 32'd0);
        chk("jhr_req", 32'(s_req), 32'd1);
        chk("jhr_addr", s_addr, 32'h0000_0200);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 100);

        // Latency-3 memory, two requests outstanding, redirect to 0x103.
        lat_lo = 3;
        lat_hi = 3;
        reset_cycles(1);
        step(1'b0, 1'b0, 32'd0, 100);
        step(1'b0, 1'b0, 32'd0, 100);
        chk("lat3_outstanding", 32'(mq.size()), 32'd2);
        step(1'b0, 1'b1, 32'h0000_0103, 100);
        seen_req = 0;
        seen_valid = 0;
        for (int i = 0; i < 20 && !(seen_req && seen_valid); i++) begin
            step(1'b0, 1'b0, 32'd0, 100);
            if (!seen_req && s_req) begin
                seen_req = 1;
                chk("redir_first_req", s_addr, 32'h0000_0100);
            end
            if (!seen_valid && s_valid) begin
                seen_valid = 1;
                chk("redir_first_addr", s_iaddr, 32'h0000_0100);
                chk("redir_first_inst", s_inst, memf(32'h0000_0100));
            end
        end
        chk("redir_req_seen", 32'(seen_req), 32'd1);
        chk("redir_valid_seen", 32'(seen_valid), 32'd1);

        // Reset with two requests in flight; their responses must be ignored.
        reset_cycles(1);
        step(1'b0, 1'b0, 32'd0, 100);
        step(1'b0, 1'b0, 32'd0, 100);
        rstn = 1'b0;
        step(1'b0, 1'b0, 32'd0, 100);
        rstn = 1'b1;
        for (int i = 0; i < 10 && mq.size() > 0; i++) begin
            step(1'b0, 1'b0, 32'd0, 0);
            chk("stale_not_pushed", 32'(s_valid), 32'd0);
        end
        chk("stale_drained", 32'(mq.size()), 32'd0);
        lat_lo = 1;
        lat_hi = 1;
        seen_valid = 0;
        for (int i = 0; i < 10 && !seen_valid; i++) begin
            step(1'b0, 1'b0, 32'd0, 100);
            if (s_valid) begin
                seen_valid = 1;
                chk("restart_addr", s_iaddr, RESET_ADDR);
                chk("restart_inst", s_inst, memf(RESET_ADDR));
            end
        end
        chk("restart_valid_seen", 32'(seen_valid), 32'd1);

        // Randomised traffic against the reference model.
        lat_lo = 1;
        lat_hi = 4;
        check_inflight = 1;
        for (int i = 0; i < 2000; i++) begin
            rj = ($urandom_range(99) < 4);
            if ($urandom_range(3) == 0) rt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else                        rt = $urandom;
            step(($urandom_range(99) < 25), rj, rt, 70);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID register `pc_id`. It owns the program counter and issues word fetches on a pipelined request/grant/response instruction-memory port. Returned instructions are buffered in a small in-order prefetch FIFO, and the FIFO head is presented to `pc_id` each cycle. It honours pipeline hold and branch/jump redirects, including discarding responses that are stale after a redirect.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: prefetch entries; also caps in-flight requests plus buffered words.
- `RESET_ADDR`, `CPU_RESET_ADDR`: PC after reset.

Ports:
- `clk_100MHz` in 1: single clock; all state updates on the rising edge.
- `arst_n` in 1: reset, synchronous, active-low.
- `hold_ena_i` in 1: pipeline hold, same signal that drives `pc_id`.
- `jump_ena_i` in 1: redirect request from EX.
- `jump_addr_i` in `INST_ADDR`: redirect target; bits [1:0] ignored and forced to 0.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out `INST_ADDR`: word-aligned fetch address.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response valid; responses arrive in order, latency ≥1 cycle after grant.
- `imem_rdata_i` in `INST`: fetched instruction.
- `inst_o` out `INST`: instruction to `pc_id`; `INST_NOP` when none is valid.
- `inst_addr_o` out `INST_ADDR`: address of `inst_o`; `CPU_RESET_ADDR` when none is valid.
- `inst_valid_o` out 1: `inst_o` holds a real fetched instruction.

## Operation
- Reset (`arst_n`=0 at an edge):
  - `fetch_pc`=`RESET_ADDR`.
  - FIFO emptied.
  - `outstanding`=0, `discard`=0.
- Outputs during reset and while empty:
  - `imem_req_o`=0, `inst_valid_o`=0.
  - `inst_o`=`INST_NOP`, `inst_addr_o`=`CPU_RESET_ADDR`.
- Issue:
  - Define `pop` = `inst_valid_o` & !`hold_ena_i` & !`jump_ena_i`.
  - `imem_req_o` = !`jump_ena_i` & (`outstanding` + `count` − `pop` < `FIFO_DEPTH`).
  - `imem_addr_o`=`fetch_pc`.
- Grant: on req&gnt, `fetch_pc` += 4 (32-bit wrap, 0xFFFF_FFFC→0) and `outstanding`++.
- Response:
  - Every `imem_rvalid_i` with `outstanding`>0 decrements `outstanding`.
  - If `discard`>0, the word is dropped and `discard` is decremented.
  - Otherwise the word is pushed with its address. The address comes from an internal response-address tracker, `resp_pc` += 4 per accepted word.
  - `rvalid` while `outstanding`==0 (e.g. after reset mid-transfer) is ignored.
- Output: FIFO head drives `inst_o`/`inst_addr_o` combinationally from registered storage. Popped on `pop`; `pc_id` captures the word at the same edge.
- Hold: no pop. Fetching continues until the FIFO plus in-flight requests reach `FIFO_DEPTH`.
- Jump, which overrides hold for fetch redirection:
  - FIFO flushed.
  - `fetch_pc` and `resp_pc` set to `jump_addr_i`&~3.
  - `discard` set to `outstanding` after this cycle's response is accounted for; a response in the jump cycle is itself dropped.
  - No request is issued in the jump cycle.
  - Next cycle: request at the target.
- Counter widths are `$clog2(FIFO_DEPTH+1)`, and the counters never exceed `FIFO_DEPTH`.

## Timing
- First fetch: request in the first cycle after reset deasserts (cycle 0).
- With a zero-wait memory (gnt same cycle, rvalid next cycle):
  - Word available on `inst_o` at cycle 2.
  - Sustained 1 instruction/cycle with `FIFO_DEPTH`=2.
- Redirect penalty with the same memory: jump at cycle J → target request J+1, target on `inst_o` at J+3. `inst_valid_o`=0 at J+1 and J+2.
- Push and pop in the same cycle on a full FIFO are legal; count is unchanged.
- Jump and rvalid together: the response is dropped.
- Jump and hold together: redirect happens; FIFO flushed.

## Structure
- `define.v` adds:
  - `INST_NOP` (32'h0000_0013).
  - `IMEM_REQ_ENABLE`.
  - Reuses `INST`, `INST_ADDR`, `RST_ENABLE`, `HOLD_ENABLE`, `JUMP_ENABLE`, `CPU_RESET_ADDR`.
- Sub-module `fetch_fifo`:
  - Parameterised depth.
  - Stores {inst, addr}.
  - Has flush, push, pop, count, and head outputs.
- PC, counters, and issue logic stay in `if_fetch`.

## Test plan
- Reset release, zero-wait memory returning `mem[a]`=a ^ 32'hA5A5_0000 → requests 0x0, 0x4, 0x8…; `inst_o`/`inst_addr_o` (0xA5A5_0000, 0x0) at cycle 2, then one word per cycle.
- `hold_ena_i` high for 5 cycles from steady state → at most 2 requests granted, `inst_o` frozen; after release, the sequence resumes with no gap or duplicate.
- Memory latency 3 with 2 requests outstanding, `jump_ena_i` with `jump_addr_i`=0x103 → both stale responses dropped; next request addr 0x100; first valid output (mem[0x100], 0x100).
- `jump_ena_i` and `hold_ena_i` together, plus `rvalid` in the same cycle → FIFO empty next cycle, `inst_valid_o`=0, request to the target issued.
- Reset mid-run with 2 outstanding, memory still returning 2 rvalids → both ignored; fetch restarts at `RESET_ADDR`.
- Redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
